// File: rtl/ff_bank_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ff_bank_cmd_arbiter
// Description : Owns a W-bit bank of JK-style flag bits and shares it between
//               two requesters. Commands (op, mask, repeat count) are granted
//               round-robin and applied to the masked bits for rep+1 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ff_bank_cmd_arbiter #(
    parameter int W     = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [W-1:0]     req0_mask,
    input  logic [REP_W-1:0] req0_rep,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [W-1:0]     req1_mask,
    input  logic [REP_W-1:0] req1_rep,
    input  logic             abort,
    output logic [W-1:0]     q,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             done_aborted
);

    localparam logic [REP_W-1:0] C_CNT_ONE = 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_APPLY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               rr_q, rr_d;
    logic [1:0]         op_q, op_d;
    logic [W-1:0]       mask_q, mask_d;
    logic [REP_W-1:0]   cnt_q, cnt_d;
    logic               id_q, id_d;
    logic [W-1:0]       bank_q, bank_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               done_id_q, done_id_d;
    logic               done_aborted_q, done_aborted_d;

    logic               w_grant0;
    logic               w_grant1;
    logic               w_idle;
    logic [W-1:0]       w_jk_next;

    // Round-robin grant: a lone requester always wins, a tie goes to rr_q.
    always_comb begin
        w_idle     = (state_q == S_IDLE);
        w_grant0   = req0_valid & (~req1_valid | ~rr_q);
        w_grant1   = req1_valid & (~req0_valid |  rr_q);
        req0_ready = w_idle & w_grant0 & ~reset;
        req1_ready = w_idle & w_grant1 & ~reset;
    end

    // JK characteristic per bit with {j,k} = op: q+ = j&~q | ~k&q, masked.
    always_comb begin
        w_jk_next = (mask_q & (({W{op_q[1]}} & ~bank_q) | ({W{~op_q[0]}} & bank_q)))
                  | (~mask_q & bank_q);
    end

    // Next-state: accept a command in IDLE, apply it for rep+1 edges in APPLY.
    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        op_d           = op_q;
        mask_d         = mask_q;
        cnt_d          = cnt_q;
        id_d           = id_q;
        bank_d         = bank_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        done_id_d      = done_id_q;
        done_aborted_d = done_aborted_q;

        case (state_q)
            S_IDLE: begin
                if (req0_ready) begin
                    op_d    = req0_op;
                    mask_d  = req0_mask;
                    cnt_d   = req0_rep;
                    id_d    = 1'b0;
                    rr_d    = 1'b1;
                    state_d = S_APPLY;
                    busy_d  = 1'b1;
                end else if (req1_ready) begin
                    op_d    = req1_op;
                    mask_d  = req1_mask;
                    cnt_d   = req1_rep;
                    id_d    = 1'b1;
                    rr_d    = 1'b0;
                    state_d = S_APPLY;
                    busy_d  = 1'b1;
                end
            end
            S_APPLY: begin
                if (abort) begin
                    // Abort wins even on the final edge: bank is left untouched.
                    state_d        = S_IDLE;
                    busy_d         = 1'b0;
                    done_d         = 1'b1;
                    done_id_d      = id_q;
                    done_aborted_d = 1'b1;
                end else begin
                    bank_d = w_jk_next;
                    if (cnt_q == '0) begin
                        state_d        = S_IDLE;
                        busy_d         = 1'b0;
                        done_d         = 1'b1;
                        done_id_d      = id_q;
                        done_aborted_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - C_CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any command and restores rr to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rr_q           <= 1'b0;
            op_q           <= 2'b00;
            mask_q         <= '0;
            cnt_q          <= '0;
            id_q           <= 1'b0;
            bank_q         <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            done_id_q      <= 1'b0;
            done_aborted_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            op_q           <= op_d;
            mask_q         <= mask_d;
            cnt_q          <= cnt_d;
            id_q           <= id_d;
            bank_q         <= bank_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            done_id_q      <= done_id_d;
            done_aborted_q <= done_aborted_d;
        end
    end

    assign q            = bank_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign done_id      = done_id_q;
    assign done_aborted = done_aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_ff_bank_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ff_bank_cmd_arbiter
// Description : Self-checking bench for ff_bank_cmd_arbiter: a command table
//               run back-to-back with a completion scoreboard, plus sequences
//               for reset, round-robin alternation and reset during APPLY.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ff_bank_cmd_arbiter;

    localparam int W     = 8;
    localparam int REP_W = 4;

    logic             clk;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_op, req1_op;
    logic [W-1:0]     req0_mask, req1_mask;
    logic [REP_W-1:0] req0_rep, req1_rep;
    logic             abort;
    logic [W-1:0]     q;
    logic             busy, done, done_id, done_aborted;

    ff_bank_cmd_arbiter #(.W(W), .REP_W(REP_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_mask    (req0_mask),
        .req0_rep     (req0_rep),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_mask    (req1_mask),
        .req1_rep     (req1_rep),
        .abort        (abort),
        .q            (q),
        .busy         (busy),
        .done         (done),
        .done_id      (done_id),
        .done_aborted (done_aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             id;
        logic [1:0]       op;
        logic [W-1:0]     mask;
        logic [REP_W-1:0] rep;
        int               abort_after;   // apply edges before abort, -1 = never
        logic [W-1:0]     exp_q;
        logic             exp_ab;
    } vec_t;

    typedef struct {
        logic         id;
        logic         ab;
        logic [W-1:0] q;
    } exp_t;

    vec_t         tbl [8];
    exp_t         sb [$];
    logic [W-1:0] mq;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] jk_model(input logic [W-1:0] cur, input logic [1:0] op,
                                              input logic [W-1:0] m);
        logic [W-1:0] r;
        case (op)
            2'b00:   r = cur;
            2'b01:   r = cur & ~m;
            2'b10:   r = cur | m;
            default: r = cur ^ m;
        endcase
        return r;
    endfunction

    task automatic drive_req(input logic id, input logic v, input logic [1:0] op,
                             input logic [W-1:0] m, input logic [REP_W-1:0] rep);
        if (id == 1'b0) begin
            req0_valid = v; req0_op = op; req0_mask = m; req0_rep = rep;
        end else begin
            req1_valid = v; req1_op = op; req1_mask = m; req1_rep = rep;
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_cmd(input vec_t c);
        int   edges;
        int   guard;
        bit   aborting;
        exp_t e;
        drive_req(c.id, 1'b1, c.op, c.mask, c.rep);
        #1;
        chk("ready_granted", c.id ? req1_ready : req0_ready, 1);
        chk("ready_other", c.id ? req0_ready : req1_ready, 0);
        e.id = c.id; e.ab = c.exp_ab; e.q = c.exp_q;
        sb.push_back(e);
        @(negedge clk);
        drive_req(c.id, 1'b0, 2'b00, '0, '0);
        chk("busy_after_accept", busy, 1);
        chk("q_unchanged_at_accept", q, mq);
        edges = 0;
        guard = 0;
        while (done !== 1'b1 && guard < 64) begin
            chk("busy_in_apply", busy, 1);
            chk("ready_blocked_in_apply", {req0_ready, req1_ready}, 0);
            aborting = (c.abort_after >= 0) && (edges == c.abort_after);
            abort = aborting;
            @(negedge clk);
            abort = 1'b0;
            if (!aborting) begin
                mq = jk_model(mq, c.op, c.mask);
                edges++;
            end
            chk("q_per_edge", q, mq);
            guard++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got done=%0b expected 1 within 64 cycles", done);
        end else if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: got done with no expectation queued, expected one");
        end else begin
            e = sb.pop_front();
            chk("done_id", done_id, e.id);
            chk("done_aborted", done_aborted, e.ab);
            chk("q_final", q, e.q);
            chk("busy_in_done_cycle", busy, 0);
            chk("apply_edges", edges, c.exp_ab ? c.abort_after : int'(c.rep) + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // id, op, mask, rep, abort_after, exp_q, exp_ab
        tbl[0] = '{1'b0, 2'b10, 8'h0F, 4'd0,  -1, 8'h0F, 1'b0};
        tbl[1] = '{1'b1, 2'b11, 8'hFF, 4'd2,  -1, 8'hF0, 1'b0};
        tbl[2] = '{1'b0, 2'b01, 8'hF0, 4'd1,  -1, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 2'b10, 8'hA5, 4'd0,  -1, 8'hA5, 1'b0};
        tbl[4] = '{1'b1, 2'b00, 8'hFF, 4'd3,  -1, 8'hA5, 1'b0};
        tbl[5] = '{1'b0, 2'b11, 8'h01, 4'd15,  4, 8'hA5, 1'b1};
        tbl[6] = '{1'b1, 2'b10, 8'h00, 4'd1,  -1, 8'hA5, 1'b0};
        tbl[7] = '{1'b0, 2'b11, 8'h3C, 4'd15, -1, 8'hA5, 1'b0};

        reset = 1'b1;
        abort = 1'b0;
        drive_req(1'b0, 1'b1, 2'b10, 8'hFF, 4'd0);
        drive_req(1'b1, 1'b0, 2'b00, 8'h00, 4'd0);
        mq = '0;

        // Reset state and reset gating of ready.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("ready0_gated_by_reset", req0_ready, 0);
        chk("reset_q", q, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_done_id", done_id, 0);
        chk("reset_done_aborted", done_aborted, 0);
        reset = 1'b0;
        drive_req(1'b1, 1'b1, 2'b10, 8'hFF, 4'd0);
        #1;
        chk("tie_after_reset_ready0", req0_ready, 1);
        chk("tie_after_reset_ready1", req1_ready, 0);
        drive_req(1'b0, 1'b0, 2'b00, 8'h00, 4'd0);
        drive_req(1'b1, 1'b0, 2'b00, 8'h00, 4'd0);
        @(negedge clk);
        chk("no_accept_q", q, 0);
        chk("no_accept_busy", busy, 0);

        // Command table, each command issued in the done cycle of the previous.
        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i]);
        end

        // Reset during APPLY of a rep-7 SET.
        drive_req(1'b0, 1'b1, 2'b10, 8'hFF, 4'd7);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 2'b00, 8'h00, 4'd0);
        chk("midreset_busy_before", busy, 1);
        @(negedge clk);
        @(negedge clk);
        chk("midreset_q_before", q, 8'hFF);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mq = '0;
        chk("midreset_q", q, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);

        // Both requesters valid continuously: grants alternate 0,1,0,1.
        drive_req(1'b0, 1'b1, 2'b01, 8'hFF, 4'd0);
        drive_req(1'b1, 1'b1, 2'b10, 8'hFF, 4'd0);
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("alt_ready0", req0_ready, (k % 4) == 0);
            chk("alt_ready1", req1_ready, (k % 4) == 2);
            if (k == 1) chk("midreset_no_late_done", done, 0);
            if (k == 2) begin
                chk("alt_q_after_clear", q, 8'h00);
                chk("alt_done_id0", done_id, 0);
            end
            if (k == 4 || k == 8) begin
                chk("alt_q_after_set", q, 8'hFF);
                chk("alt_done_id1", done_id, 1);
            end
            @(negedge clk);
        end
        drive_req(1'b0, 1'b0, 2'b00, 8'h00, 4'd0);
        drive_req(1'b1, 1'b0, 2'b00, 8'h00, 4'd0);

        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
